multi_issue_queue: RTL and testbench

// - Parametrised in-order issue buffer between the decode stage and the scoreboard/read-operands logic.
// - Accepts up to NrEnq decoded scoreboard entries per cycle and presents up to NrDeq oldest entries per cycle.
// - Generalises the fixed SUPERSCALAR+1 handshake to independent enqueue/dequeue widths and a configurable depth.
// - Adds flush support and occupancy reporting.

---
 rtl/multi_issue_queue_pkg.sv | 18 +
 rtl/multi_issue_queue_if.sv | 37 +++
 rtl/iq_leading_ones.sv | 21 ++
 rtl/multi_issue_queue.sv | 127 ++++++++++++
 tb/tb_multi_issue_queue.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/multi_issue_queue_pkg.sv
// Shared types and helpers for the multi-issue queue.
//   cva6_cfg_t / cva6_cfg_empty : minimal core configuration type and its default value.
//   clog2_ptr()                 : pointer width for a given slot count (never 0).
// Optional feature: MULTI_ISSUE_QUEUE_BYPASS_EN (see rtl/multi_issue_queue.sv).
package multi_issue_queue_pkg;

  typedef struct packed {
    logic [7:0] nr_commit_ports;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  // A one-slot queue still needs a one-bit pointer so the typedef stays legal.
  function automatic int unsigned clog2_ptr(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/multi_issue_queue_if.sv
// Handshake bundle between decode (enqueue side), issue (dequeue side) and
// the queue itself.
//   master : drives flush_i, enq_valid_i, enq_data_i, deq_ack_i.
//   slave  : the queue; drives enq_ack_o, deq_valid_o, deq_data_o,
//            count_o, full_o, empty_o.
// Handshake: a lane transfers in a cycle when its valid and its ack are both
// high at the rising clock edge. Lanes are ordered oldest-first (lane 0) and
// only a contiguous prefix of lanes starting at lane 0 ever transfers; a
// valid lane sitting after an idle lane waits, and an ack after a dropped
// ack is ignored. Flush suppresses every valid and ack in its cycle.
interface multi_issue_queue_if #(
  parameter type         entry_t = logic,
  parameter int unsigned Depth   = 8,
  parameter int unsigned NrEnq   = 2,
  parameter int unsigned NrDeq   = 2
);
  logic                     flush_i;
  logic   [NrEnq-1:0]       enq_valid_i;
  entry_t [NrEnq-1:0]       enq_data_i;
  logic   [NrEnq-1:0]       enq_ack_o;
  logic   [NrDeq-1:0]       deq_valid_o;
  entry_t [NrDeq-1:0]       deq_data_o;
  logic   [NrDeq-1:0]       deq_ack_i;
  logic   [$clog2(Depth):0] count_o;
  logic                     full_o;
  logic                     empty_o;

  modport master (
    output flush_i, enq_valid_i, enq_data_i, deq_ack_i,
    input  enq_ack_o, deq_valid_o, deq_data_o, count_o, full_o, empty_o
  );

  modport slave (
    input  flush_i, enq_valid_i, enq_data_i, deq_ack_i,
    output enq_ack_o, deq_valid_o, deq_data_o, count_o, full_o, empty_o
  );
endinterface

// File: rtl/iq_leading_ones.sv
// Counts the run of ones starting at bit 0 of in_bits.
//   in_bits : Width-bit vector.
//   ones    : length of the unbroken run of ones from bit 0.
module iq_leading_ones #(
  parameter int unsigned Width = 2,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] in_bits,
  output logic [CntW-1:0]  ones
);
  logic run;

  always_comb begin
    ones = '0;
    run  = 1'b1;
    for (int i = 0; i < Width; i++) begin
      run = run & in_bits[i];
      if (run) ones = ones + CntW'(1);
    end
  end
endmodule

// File: rtl/multi_issue_queue.sv
// In-order issue buffer between decode and the scoreboard/read-operands
// logic. Accepts up to NrEnq entries per cycle and presents the NrDeq oldest
// entries per cycle, with flush and registered occupancy.
//   clk_i, rst_i : clock, asynchronous active-high reset.
//   bus          : multi_issue_queue_if.slave (enqueue/dequeue lanes,
//                  flush, count/full/empty).
// Optional feature: define MULTI_ISSUE_QUEUE_BYPASS_EN to let an empty queue
// forward enqueue lanes straight to the dequeue lanes in the same cycle.
module multi_issue_queue
  import multi_issue_queue_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
  parameter type         entry_t = logic,
  parameter int unsigned Depth   = 8,
  parameter int unsigned NrEnq   = 2,
  parameter int unsigned NrDeq   = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  multi_issue_queue_if.slave  bus
);
  localparam int unsigned PtrW = clog2_ptr(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam int unsigned EnqW = $clog2(NrEnq + 1);
  localparam int unsigned DeqW = $clog2(NrDeq + 1);

  typedef logic [PtrW-1:0] iq_ptr_t;
  typedef logic [CntW-1:0] iq_cnt_t;

  iq_ptr_t head_q, tail_q;
  iq_cnt_t count_q;
  entry_t  slots [Depth];

  logic [EnqW-1:0]  enq_run;
  logic [DeqW-1:0]  deq_run;
  iq_cnt_t          free_slots, enq_run_ext, n_enq, n_deq, byp_deq;
  logic [NrDeq-1:0] deq_valid;
  iq_ptr_t          wr_idx [NrEnq];
  logic [NrEnq-1:0] wr_en;

  iq_leading_ones #(.Width(NrEnq), .CntW(EnqW)) u_enq_ones (
    .in_bits (bus.enq_valid_i),
    .ones    (enq_run)
  );

  iq_leading_ones #(.Width(NrDeq), .CntW(DeqW)) u_deq_ones (
    .in_bits (bus.deq_ack_i & deq_valid),
    .ones    (deq_run)
  );

  // Space comes from the registered count only, so a same-cycle dequeue
  // never makes room for an enqueue.
  always_comb begin
    free_slots  = iq_cnt_t'(Depth) - count_q;
    enq_run_ext = iq_cnt_t'(enq_run);
    n_enq       = '0;
    if (!bus.flush_i) n_enq = (enq_run_ext > free_slots) ? free_slots : enq_run_ext;
    for (int k = 0; k < NrEnq; k++) bus.enq_ack_o[k] = iq_cnt_t'(k) < n_enq;
  end

  always_comb begin
    for (int k = 0; k < NrDeq; k++) begin
      deq_valid[k]      = (iq_cnt_t'(k) < count_q) && !bus.flush_i;
      bus.deq_data_o[k] = slots[head_q + iq_ptr_t'(k)];
    end
`ifdef MULTI_ISSUE_QUEUE_BYPASS_EN
    if (count_q == '0 && !bus.flush_i) begin
      for (int k = 0; k < NrDeq; k++) begin
        deq_valid[k] = 1'b0;
        if (k < NrEnq) begin
          deq_valid[k]      = iq_cnt_t'(k) < n_enq;
          bus.deq_data_o[k] = bus.enq_data_i[k];
        end
      end
    end
`endif
    bus.deq_valid_o = deq_valid;
  end

  // Lanes consumed straight from the enqueue side never touch storage. With
  // head == tail when empty, skipping them keeps the remaining entries at
  // the new head.
  always_comb begin
    n_deq   = iq_cnt_t'(deq_run);
    byp_deq = '0;
`ifdef MULTI_ISSUE_QUEUE_BYPASS_EN
    if (count_q == '0) byp_deq = n_deq;
`endif
    for (int k = 0; k < NrEnq; k++) begin
      wr_idx[k] = tail_q + iq_ptr_t'(k);
      wr_en[k]  = (iq_cnt_t'(k) < n_enq) && (iq_cnt_t'(k) >= byp_deq);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + iq_ptr_t'(n_deq);
      tail_q  <= tail_q + iq_ptr_t'(n_enq);
      count_q <= count_q + n_enq - n_deq;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NrEnq; k++) begin
      if (wr_en[k]) slots[wr_idx[k]] <= bus.enq_data_i[k];
    end
  end

  assign bus.count_o = count_q;
  assign bus.full_o  = count_q == iq_cnt_t'(Depth);
  assign bus.empty_o = count_q == '0;

`ifndef SYNTHESIS
  count_bounds_a : assert property (@(posedge clk_i) disable iff (rst_i)
    (count_q <= iq_cnt_t'(Depth)) &&
    ({1'b0, count_q} + {1'b0, n_enq} >= {1'b0, n_deq}));
`endif

endmodule

// File: tb/tb_multi_issue_queue.sv
// Directed bench for multi_issue_queue: Depth=8, two enqueue and two dequeue
// lanes, 8-bit entries.
module tb_multi_issue_queue;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] next_tag;
  logic [7:0] exp_d0, exp_d1;

  always #5 clk_i = ~clk_i;

  multi_issue_queue_if #(.entry_t(logic [7:0]), .Depth(8), .NrEnq(2), .NrDeq(2)) q_if ();

  multi_issue_queue #(.entry_t(logic [7:0]), .Depth(8), .NrEnq(2), .NrDeq(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (q_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Inputs change 1 ns after the edge; outputs are sampled 1 ns later.
  task automatic drive(input logic fl, input logic [1:0] ev, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [1:0] da);
    q_if.flush_i       = fl;
    q_if.enq_valid_i   = ev;
    q_if.enq_data_i[0] = d0;
    q_if.enq_data_i[1] = d1;
    q_if.deq_ack_i     = da;
    #1;
  endtask

  initial begin
    drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_count", q_if.count_o, 0);
    check("rst_empty", q_if.empty_o, 1);
    check("rst_full", q_if.full_o, 0);
    check("rst_deq_valid", q_if.deq_valid_o, 2'b00);
    rst_i = 1'b0;
    tick();

    // Prefix rule: lane 1 valid behind an idle lane 0 is never taken.
    drive(1'b0, 2'b10, 8'h55, 8'h66, 2'b00);
    check("prefix_ack", q_if.enq_ack_o, 2'b00);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
    check("prefix_count", q_if.count_o, 0);

    // Fill with tags 0..7.
    next_tag = 8'd0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'b11, next_tag, next_tag + 8'd1, 2'b00);
      check("fill_ack", q_if.enq_ack_o, 2'b11);
      exp_q.push_back(next_tag);
      exp_q.push_back(next_tag + 8'd1);
      next_tag = next_tag + 8'd2;
      tick();
    end
    drive(1'b0, 2'b11, 8'hee, 8'hef, 2'b00);
    check("fill_count", q_if.count_o, 8);
    check("fill_full", q_if.full_o, 1);
    check("full_ack", q_if.enq_ack_o, 2'b00);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
    check("full_hold_count", q_if.count_o, 8);

    // Wrap-around: the first cycle starts full, so only the dequeue lands;
    // from then on two in, two out, with occupancy settling at 6.
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 2'b11, next_tag, next_tag + 8'd1, 2'b11);
      check("wrap_deq_valid", q_if.deq_valid_o, 2'b11);
      check("wrap_enq_ack", q_if.enq_ack_o, (i == 0) ? 2'b00 : 2'b11);
      exp_d0 = exp_q.pop_front();
      exp_d1 = exp_q.pop_front();
      check("wrap_deq0", q_if.deq_data_o[0], exp_d0);
      check("wrap_deq1", q_if.deq_data_o[1], exp_d1);
      if (i != 0) begin
        exp_q.push_back(next_tag);
        exp_q.push_back(next_tag + 8'd1);
        next_tag = next_tag + 8'd2;
      end
      tick();
      drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
      check("wrap_count", q_if.count_o, 6);
    end
    check("wrap_last_tag", next_tag, 28);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b11);
      exp_d0 = exp_q.pop_front();
      exp_d1 = exp_q.pop_front();
      check("drain_deq0", q_if.deq_data_o[0], exp_d0);
      check("drain_deq1", q_if.deq_data_o[1], exp_d1);
      tick();
    end
    drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
    check("drain_count", q_if.count_o, 0);
    check("drain_empty", q_if.empty_o, 1);
    check("drain_deq_valid", q_if.deq_valid_o, 2'b00);

    // Flush at occupancy 5 beats a simultaneous enqueue and dequeue.
    drive(1'b0, 2'b11, 8'h40, 8'h41, 2'b00);
    tick();
    drive(1'b0, 2'b11, 8'h42, 8'h43, 2'b00);
    tick();
    drive(1'b0, 2'b01, 8'h44, 8'h45, 2'b00);
    tick();
    drive(1'b1, 2'b11, 8'h46, 8'h47, 2'b11);
    check("flush_pre_count", q_if.count_o, 5);
    check("flush_enq_ack", q_if.enq_ack_o, 2'b00);
    check("flush_deq_valid", q_if.deq_valid_o, 2'b00);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
    check("flush_count", q_if.count_o, 0);
    check("flush_empty", q_if.empty_o, 1);

    // Fresh entries after flush start at the head again.
    drive(1'b0, 2'b11, 8'ha0, 8'ha1, 2'b00);
`ifndef MULTI_ISSUE_QUEUE_BYPASS_EN
    check("latency_deq_valid", q_if.deq_valid_o, 2'b00);
`endif
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
    check("post_flush_valid", q_if.deq_valid_o, 2'b11);
    check("post_flush_deq0", q_if.deq_data_o[0], 8'ha0);
    check("post_flush_deq1", q_if.deq_data_o[1], 8'ha1);

    // An ack on lane 1 alone is ignored.
    drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b10);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
    check("gap_ack_count", q_if.count_o, 2);
    check("gap_ack_deq0", q_if.deq_data_o[0], 8'ha0);

    // Enqueue capped by free space: at 7, only one of two lanes is taken.
    drive(1'b0, 2'b11, 8'hc0, 8'hc1, 2'b00);
    tick();
    drive(1'b0, 2'b11, 8'hc2, 8'hc3, 2'b00);
    tick();
    drive(1'b0, 2'b01, 8'hc4, 8'hc5, 2'b00);
    tick();
    drive(1'b0, 2'b11, 8'hc6, 8'hc7, 2'b00);
    check("cap_count", q_if.count_o, 7);
    check("cap_ack", q_if.enq_ack_o, 2'b01);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
    check("cap_full", q_if.full_o, 1);

    // Reset mid-stream clears state in the same cycle, before any edge.
    rst_i = 1'b1;
    #1;
    check("midrst_count", q_if.count_o, 0);
    check("midrst_empty", q_if.empty_o, 1);
    check("midrst_deq_valid", q_if.deq_valid_o, 2'b00);
    tick();
    rst_i = 1'b0;
    tick();

`ifdef MULTI_ISSUE_QUEUE_BYPASS_EN
    drive(1'b0, 2'b11, 8'hb0, 8'hb1, 2'b01);
    check("byp_deq_valid", q_if.deq_valid_o, 2'b11);
    check("byp_deq0", q_if.deq_data_o[0], 8'hb0);
    check("byp_enq_ack", q_if.enq_ack_o, 2'b11);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
    check("byp_count", q_if.count_o, 1);
    check("byp_next_deq0", q_if.deq_data_o[0], 8'hb1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
